// File: rtl/dsp_mac_pipe_if.sv
// Operand/result bundle for dsp_mac_pipe; the slave modport is the slice's view.
// in_valid qualifies one sample per cycle with no backpressure; out_valid is high for one CE cycle per result.
interface dsp_mac_pipe_if #(
   parameter int A_WIDTH = 18,
   parameter int B_WIDTH = 18,
   parameter int P_WIDTH = 48
);
   logic                       CE;
   logic                       in_valid;
   logic [A_WIDTH-1:0]         A;
   logic [B_WIDTH-1:0]         B;
   logic [B_WIDTH-1:0]         BCIN;
   logic [B_WIDTH-1:0]         D;
   logic [P_WIDTH-1:0]         C;
   logic [P_WIDTH-1:0]         PCIN;
   logic                       CARRYIN;
   logic [7:0]                 OPMODE;
   logic                       out_valid;
   logic [B_WIDTH-1:0]         BCOUT;
   logic [A_WIDTH+B_WIDTH-1:0] M;
   logic [P_WIDTH-1:0]         P;
   logic [P_WIDTH-1:0]         PCOUT;
   logic                       CARRYOUT;
   logic                       CARRYOUTF;
   logic                       OVERFLOW;

   modport slave (
      input  CE, in_valid, A, B, BCIN, D, C, PCIN, CARRYIN, OPMODE,
      output out_valid, BCOUT, M, P, PCOUT, CARRYOUT, CARRYOUTF, OVERFLOW
   );
   modport master (
      output CE, in_valid, A, B, BCIN, D, C, PCIN, CARRYIN, OPMODE,
      input  out_valid, BCOUT, M, P, PCOUT, CARRYOUT, CARRYOUTF, OVERFLOW
   );
endinterface

// File: rtl/dsp_mac_pipe.sv
// Pipelined pre-add / multiply / post-add slice with valid tracking, valid-gated
// register loads and optional saturation. Each stage register is optional.
module dsp_mac_pipe #(
   parameter int A_WIDTH     = 18,
   parameter int B_WIDTH     = 18,
   parameter int P_WIDTH     = 48,
   parameter int IREG        = 1,
   parameter int MREG        = 1,
   parameter int PREG        = 1,
   parameter int B_INPUT     = 0,
   parameter int CARRYIN_SEL = 0,
   parameter int SAT_EN      = 0
) (
   input  logic          clk,
   input  logic          RST,
   dsp_mac_pipe_if.slave bus
);
   localparam int MW = A_WIDTH + B_WIDTH;
   localparam int SW = P_WIDTH + 2;

   typedef struct packed {
      logic [A_WIDTH-1:0] a;
      logic [B_WIDTH-1:0] bsel;
      logic [B_WIDTH-1:0] d;
      logic [P_WIDTH-1:0] c;
      logic [P_WIDTH-1:0] pcin;
      logic               cin;
      logic               sub;
      logic               pre_sub;
      logic               pre_en;
      logic [1:0]         zsel;
      logic [1:0]         xsel;
   } s1_t;

   typedef struct packed {
      logic [MW-1:0]      m;
      logic [P_WIDTH-1:0] xcat;
      logic [P_WIDTH-1:0] c;
      logic [P_WIDTH-1:0] pcin;
      logic               cin;
      logic               sub;
      logic [1:0]         zsel;
      logic [1:0]         xsel;
   } s2_t;

   s1_t                w_s1_in, w_s1;
   s2_t                w_s2_in, w_s2;
   logic               w_s1_v, w_s2_v;
   logic [B_WIDTH-1:0] w_bpre;
   logic [MW-1:0]      w_m;
   logic [P_WIDTH-1:0] w_x, w_z, w_pfb, w_pres;
   logic [SW-1:0]      w_xs, w_zs, w_cs, w_s;
   logic               w_ovf, w_cout;

   always_comb begin
      w_s1_in.a       = bus.A;
      w_s1_in.bsel    = (B_INPUT != 0) ? bus.BCIN : bus.B;
      w_s1_in.d       = bus.D;
      w_s1_in.c       = bus.C;
      w_s1_in.pcin    = bus.PCIN;
      w_s1_in.cin     = (CARRYIN_SEL != 0) ? bus.CARRYIN : bus.OPMODE[5];
      w_s1_in.sub     = bus.OPMODE[7];
      w_s1_in.pre_sub = bus.OPMODE[6];
      w_s1_in.pre_en  = bus.OPMODE[4];
      w_s1_in.zsel    = bus.OPMODE[3:2];
      w_s1_in.xsel    = bus.OPMODE[1:0];
   end

   if (IREG != 0) begin : g_ireg
      s1_t  r_s1;
      logic r_v;
      always_ff @(posedge clk) begin
         if (RST) begin
            r_s1 <= '0;
            r_v  <= 1'b0;
         end else if (bus.CE) begin
            r_v <= bus.in_valid;
            if (bus.in_valid) r_s1 <= w_s1_in;
         end
      end
      assign w_s1   = r_s1;
      assign w_s1_v = r_v;
   end else begin : g_no_ireg
      assign w_s1   = w_s1_in;
      assign w_s1_v = bus.in_valid;
   end

   always_comb begin
      w_bpre = w_s1.bsel;
      if (w_s1.pre_en) w_bpre = w_s1.pre_sub ? (w_s1.d - w_s1.bsel) : (w_s1.d + w_s1.bsel);
   end

   assign w_m = $signed({{B_WIDTH{w_s1.a[A_WIDTH-1]}}, w_s1.a}) *
                $signed({{A_WIDTH{w_bpre[B_WIDTH-1]}}, w_bpre});

   always_comb begin
      w_s2_in.m    = w_m;
      w_s2_in.xcat = P_WIDTH'({w_s1.d, w_s1.a, w_s1.bsel});
      w_s2_in.c    = w_s1.c;
      w_s2_in.pcin = w_s1.pcin;
      w_s2_in.cin  = w_s1.cin;
      w_s2_in.sub  = w_s1.sub;
      w_s2_in.zsel = w_s1.zsel;
      w_s2_in.xsel = w_s1.xsel;
   end

   if (MREG != 0) begin : g_mreg
      s2_t  r_s2;
      logic r_v;
      always_ff @(posedge clk) begin
         if (RST) begin
            r_s2 <= '0;
            r_v  <= 1'b0;
         end else if (bus.CE) begin
            r_v <= w_s1_v;
            if (w_s1_v) r_s2 <= w_s2_in;
         end
      end
      assign w_s2   = r_s2;
      assign w_s2_v = r_v;
   end else begin : g_no_mreg
      assign w_s2   = w_s2_in;
      assign w_s2_v = w_s1_v;
   end

   // Signed result in P_WIDTH+2 bits; the unsigned carry bit differs from bit P
   // only by the two operand sign bits, so one adder yields P, carry and overflow.
   always_comb begin
      case (w_s2.xsel)
         2'b00:   w_x = '0;
         2'b01:   w_x = P_WIDTH'($signed(w_s2.m));
         2'b10:   w_x = w_pfb;
         default: w_x = w_s2.xcat;
      endcase
      case (w_s2.zsel)
         2'b00:   w_z = '0;
         2'b01:   w_z = w_s2.pcin;
         2'b10:   w_z = w_pfb;
         default: w_z = w_s2.c;
      endcase
      w_xs   = {{2{w_x[P_WIDTH-1]}}, w_x};
      w_zs   = {{2{w_z[P_WIDTH-1]}}, w_z};
      w_cs   = {{(SW-1){1'b0}}, w_s2.cin};
      w_s    = w_s2.sub ? (w_zs - (w_xs + w_cs)) : (w_zs + w_xs + w_cs);
      w_cout = w_s[P_WIDTH] ^ w_z[P_WIDTH-1] ^ w_x[P_WIDTH-1];
      w_ovf  = (w_s[SW-1:P_WIDTH-1] != 3'b000) && (w_s[SW-1:P_WIDTH-1] != 3'b111);
      w_pres = w_s[P_WIDTH-1:0];
      if ((SAT_EN != 0) && w_ovf)
         w_pres = w_s[P_WIDTH-1] ? {1'b0, {(P_WIDTH-1){1'b1}}} : {1'b1, {(P_WIDTH-1){1'b0}}};
   end

   if (PREG != 0) begin : g_preg
      logic [P_WIDTH-1:0] r_p;
      logic               r_cout, r_ovf, r_v;
      always_ff @(posedge clk) begin
         if (RST) begin
            r_p    <= '0;
            r_cout <= 1'b0;
            r_ovf  <= 1'b0;
            r_v    <= 1'b0;
         end else if (bus.CE) begin
            r_v <= w_s2_v;
            if (w_s2_v) begin
               r_p    <= w_pres;
               r_cout <= w_cout;
               r_ovf  <= w_ovf;
            end
         end
      end
      assign w_pfb         = r_p;
      assign bus.P         = r_p;
      assign bus.CARRYOUT  = r_cout;
      assign bus.OVERFLOW  = r_ovf;
      assign bus.out_valid = r_v;
   end else begin : g_no_preg
      assign w_pfb         = '0;
      assign bus.P         = w_pres;
      assign bus.CARRYOUT  = w_cout;
      assign bus.OVERFLOW  = w_ovf;
      assign bus.out_valid = w_s2_v;
   end

   assign bus.BCOUT     = w_bpre;
   assign bus.M         = w_s2.m;
   assign bus.PCOUT     = bus.P;
   assign bus.CARRYOUTF = bus.CARRYOUT;
endmodule

// File: tb/tb_dsp_mac_pipe.sv
// Directed bench for dsp_mac_pipe: a plain instance and a saturating instance share
// one stimulus stream; expected results are queued per instance and checked by a monitor.
module tb_dsp_mac_pipe;
   localparam int AW = 18;
   localparam int BW = 18;
   localparam int PW = 48;
   localparam int EW = PW + 2;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   logic          ce, iv, cin;
   logic [AW-1:0] a;
   logic [BW-1:0] b, bcin, d;
   logic [PW-1:0] c, pcin;
   logic [7:0]    op;

   dsp_mac_pipe_if #(.A_WIDTH(AW), .B_WIDTH(BW), .P_WIDTH(PW)) bus0 ();
   dsp_mac_pipe_if #(.A_WIDTH(AW), .B_WIDTH(BW), .P_WIDTH(PW)) bus1 ();

   dsp_mac_pipe #(.A_WIDTH(AW), .B_WIDTH(BW), .P_WIDTH(PW), .SAT_EN(0))
      dut0 (.clk(clk), .RST(rst), .bus(bus0));
   dsp_mac_pipe #(.A_WIDTH(AW), .B_WIDTH(BW), .P_WIDTH(PW), .SAT_EN(1))
      dut1 (.clk(clk), .RST(rst), .bus(bus1));

   assign bus0.CE = ce;      assign bus1.CE = ce;
   assign bus0.in_valid = iv; assign bus1.in_valid = iv;
   assign bus0.A = a;        assign bus1.A = a;
   assign bus0.B = b;        assign bus1.B = b;
   assign bus0.BCIN = bcin;  assign bus1.BCIN = bcin;
   assign bus0.D = d;        assign bus1.D = d;
   assign bus0.C = c;        assign bus1.C = c;
   assign bus0.PCIN = pcin;  assign bus1.PCIN = pcin;
   assign bus0.CARRYIN = cin; assign bus1.CARRYIN = cin;
   assign bus0.OPMODE = op;  assign bus1.OPMODE = op;

   logic [EW-1:0] exp0_q[$];
   logic [EW-1:0] exp1_q[$];
   int   n_vec  = 0;
   int   n_miss = 0;
   logic ce_q   = 1'b0;

   task automatic chk(input string name, input logic [EW-1:0] act, input logic [EW-1:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_miss++;
         $display("FAIL %s: got %h want %h", name, act, exp);
      end
   endtask

   task automatic unexpected(input string name);
      n_vec++;
      n_miss++;
      $display("FAIL %s: got out_valid=1 want no result pending", name);
   endtask

   // ---------------- monitor / scoreboard ----------------
   always @(posedge clk) ce_q <= ce;

   always @(negedge clk) begin
      logic [EW-1:0] e;
      if (ce_q && bus0.out_valid) begin
         if (exp0_q.size() == 0) unexpected("dut0_extra");
         else begin
            e = exp0_q.pop_front();
            chk("dut0_result", {bus0.OVERFLOW, bus0.CARRYOUT, bus0.P}, e);
            chk("dut0_cascade", {1'b0, bus0.CARRYOUTF, bus0.PCOUT}, {1'b0, e[PW:0]});
         end
      end
      if (ce_q && bus1.out_valid) begin
         if (exp1_q.size() == 0) unexpected("dut1_extra");
         else begin
            e = exp1_q.pop_front();
            chk("dut1_result", {bus1.OVERFLOW, bus1.CARRYOUT, bus1.P}, e);
         end
      end
   end

   // ---------------- driver tasks ----------------
   task automatic drv(input logic v, input logic [AW-1:0] ia, input logic [BW-1:0] ib,
                      input logic [BW-1:0] id, input logic [PW-1:0] ic, input logic [7:0] iop);
      iv = v; a = ia; b = ib; d = id; c = ic; op = iop;
      @(posedge clk);
      #1;
   endtask

   task automatic idle(input int n);
      repeat (n) drv(1'b0, '0, '0, '0, '0, 8'h00);
   endtask

   task automatic push(input logic [PW-1:0] p, input logic co, input logic ov);
      exp0_q.push_back({ov, co, p});
      exp1_q.push_back({ov, co, p});
   endtask

   task automatic push2(input logic [PW-1:0] p0, input logic [PW-1:0] p1,
                        input logic co, input logic ov);
      exp0_q.push_back({ov, co, p0});
      exp1_q.push_back({ov, co, p1});
   endtask

   task automatic do_reset(input int n);
      rst = 1'b1;
      idle(n);
      rst = 1'b0;
   endtask

   // ---------------- stimulus ----------------
   initial begin
      rst = 1'b1; ce = 1'b1; iv = 1'b0; cin = 1'b0;
      a = '0; b = '0; bcin = '0; d = '0; c = '0; pcin = '0; op = '0;
      @(posedge clk);
      #1;

      // reset with random live traffic on every input
      repeat (2) begin
         iv = 1'b1; a = AW'($urandom); b = BW'($urandom); bcin = BW'($urandom);
         d = BW'($urandom); c = PW'({$urandom, $urandom}); pcin = PW'({$urandom, $urandom});
         cin = 1'($urandom_range(0, 1)); op = 8'($urandom);
         @(posedge clk);
         #1;
      end
      chk("rst_p", EW'(bus0.P), EW'(0));
      chk("rst_m", EW'(bus0.M), EW'(0));
      chk("rst_valid", EW'(bus0.out_valid), EW'(0));
      chk("rst_carry", EW'(bus0.CARRYOUT), EW'(0));
      chk("rst_p_sat", EW'(bus1.P), EW'(0));
      rst = 1'b0; bcin = '0; pcin = '0; cin = 1'b0;
      idle(1);

      // two samples in flight when reset hits: neither may emerge
      drv(1'b1, 18'd2, 18'd450, 18'd500, '0, 8'h11);
      drv(1'b1, 18'd2, 18'd450, 18'd500, '0, 8'h51);
      do_reset(1);
      idle(5);
      chk("midrst_valid", EW'(bus0.out_valid), EW'(0));
      chk("midrst_p", EW'(bus0.P), EW'(0));

      // pre-adder add / subtract
      drv(1'b1, 18'd2, 18'd450, 18'd500, '0, 8'h11); push(48'd1900, 1'b0, 1'b0);
      drv(1'b1, 18'd2, 18'd450, 18'd500, '0, 8'h51); push(48'd100, 1'b0, 1'b0);
      idle(4);
      chk("bcout_presub", EW'(bus0.BCOUT), EW'(50));
      chk("m_held", EW'(bus0.M), EW'(100));

      // accumulate with a bubble between samples 2 and 3
      do_reset(1);
      drv(1'b1, 18'd3, 18'd4, '0, '0, 8'h09); push(48'd12, 1'b0, 1'b0);
      drv(1'b1, 18'd3, 18'd4, '0, '0, 8'h09); push(48'd24, 1'b0, 1'b0);
      idle(1);
      drv(1'b1, 18'd3, 18'd4, '0, '0, 8'h09); push(48'd36, 1'b0, 1'b0);
      drv(1'b1, 18'd3, 18'd4, '0, '0, 8'h09); push(48'd48, 1'b0, 1'b0);
      chk("bubble_p_held", EW'(bus0.P), EW'(24));
      chk("bubble_valid", EW'(bus0.out_valid), EW'(0));
      idle(5);

      // accumulate with CE low for two cycles mid-stream
      do_reset(1);
      drv(1'b1, 18'd3, 18'd4, '0, '0, 8'h09); push(48'd12, 1'b0, 1'b0);
      drv(1'b1, 18'd3, 18'd4, '0, '0, 8'h09); push(48'd24, 1'b0, 1'b0);
      drv(1'b1, 18'd3, 18'd4, '0, '0, 8'h09); push(48'd36, 1'b0, 1'b0);
      ce = 1'b0;
      repeat (2) begin
         drv(1'b1, 18'd3, 18'd4, '0, '0, 8'h09);
         chk("ce_p_frozen", EW'(bus0.P), EW'(12));
         chk("ce_m_frozen", EW'(bus0.M), EW'(12));
         chk("ce_valid_frozen", EW'(bus0.out_valid), EW'(1));
      end
      ce = 1'b1;
      drv(1'b1, 18'd3, 18'd4, '0, '0, 8'h09); push(48'd48, 1'b0, 1'b0);
      idle(5);

      // post-adder subtract with carry-in, unsigned carry out, concatenated X
      drv(1'b1, 18'd5, 18'd6, '0, 48'd100, 8'hAD);          push(48'd69, 1'b0, 1'b0);
      drv(1'b1, 18'd1, 18'd1, '0, 48'hFFFF_FFFF_FFFF, 8'h0D); push(48'd0, 1'b1, 1'b0);
      drv(1'b1, 18'd1, 18'd2, '0, '0, 8'h03);               push(48'd262146, 1'b0, 1'b0);
      idle(5);

      // signed overflow: wrap on dut0, saturate on dut1
      drv(1'b1, 18'd1, 18'd1, '0, 48'h7FFF_FFFF_FFFF, 8'h0D);
      push2(48'h8000_0000_0000, 48'h7FFF_FFFF_FFFF, 1'b0, 1'b1);
      drv(1'b1, 18'd1, 18'd1, '0, 48'h8000_0000_0000, 8'h8D);
      push2(48'h7FFF_FFFF_FFFF, 48'h8000_0000_0000, 1'b0, 1'b1);
      idle(6);

      chk("drain_q0", EW'(exp0_q.size()), EW'(0));
      chk("drain_q1", EW'(exp1_q.size()), EW'(0));
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
      $finish;
   end
endmodule
